spdu_tb_ctrl: RTL and testbench
===============================

// Module: spdu_tb_ctrl
// PURPOSE
//  Traceback controller for the 4-state (K=3) Viterbi survivor path decode unit (spdu).
//  Buffers one 4-bit survivor-decision vector per trellis step in a circular buffer.
//  Sequences the external 4:1 survivor mux: data inputs come from a buffered vector, selects from the current trace state.
//  Walks TB_LEN steps backward, then emits one decoded bit and retires the oldest vector.
// PARAMETERS
//  TB_LEN  8   traceback depth in trellis steps; legal range 2..DEPTH-1
//  DEPTH   16  survivor buffer entries; power of 2
//  AW      4   buffer pointer width; log2(DEPTH)
// PORTS
//  clk          in   1   single clock; all logic on rising edge
//  reset        in   1   synchronous reset, active-high
//  sv_valid     in   1   survivor vector offered this cycle
//  sv_in        in   4   survivor decision bits; bit i belongs to state i
//  sv_ready     out  1   buffer can accept sv_in (count != DEPTH)
//  start_state  in   2   traceback start state; sampled on entry to TRACE
//  mux_in       out  4   vector under trace, to survivor mux inputs in0..in3
//  mux_d0       out  1   survivor mux select LSB (= trace state[0])
//  mux_d1       out  1   survivor mux select MSB (= trace state[1])
//  mux_out      in   1   survivor mux output; combinational, same cycle
//  dec_bit      out  1   decoded bit; valid only while dec_valid=1
//  dec_valid    out  1   one-cycle pulse per decoded bit
//  busy         out  1   FSM is in TRACE or EMIT
// BEHAVIOUR
//  Reset (sync, high): wr_ptr=rd_ptr=tail=0, count=0, FSM=FILL, trace state=00, step=0.
//   All outputs are 0 while reset is high; sv_ready=1 from the first cycle after reset.
//  Write: accepted when sv_valid && sv_ready. mem[wr_ptr]<=sv_in, wr_ptr++ (wraps mod DEPTH).
//   Writes are accepted in every FSM state. Writes offered while sv_ready=0 are dropped silently.
//  FSM FILL: when count>=TB_LEN, go to TRACE next cycle.
//   On that transition: rd_ptr<=wr_ptr-1 (newest entry), state<=start_state, step<=0.
//   A write in the same cycle is not part of the window.
//  FSM TRACE: one trellis step per cycle.
//   Drive mux_in=mem[rd_ptr], mux_d1=state[1], mux_d0=state[0].
//   On the clock edge: state<={state[0],mux_out}, rd_ptr-- (wraps), step++.
//   After TB_LEN steps (step==TB_LEN-1 at the edge), go to EMIT.
//  FSM EMIT: one cycle long.
//   dec_valid=1, dec_bit=state[1] of the final trace state.
//   Pop the oldest entry: tail++, count--. Return to FILL.
//  Outside TRACE: mux_in=0, mux_d0=0, mux_d1=0.
//  Latency: TRACE entry to dec_valid = TB_LEN+1 cycles; throughput is 1 bit per TB_LEN+2 cycles.
//  Count arithmetic:
//   AW+1 bits wide.
//   Write and pop in the same cycle leave count unchanged.
//   A pop never occurs with count=0, because EMIT requires count>=TB_LEN.
//  Window stability: during TRACE the traced entries are never overwritten.
//   Reason: count>=TB_LEN entries stay resident until EMIT, and wr_ptr cannot reach tail while count<DEPTH.
//  start_state changes during TRACE are ignored.
//  Reset mid-TRACE or mid-EMIT:
//   Abort at once; no dec_valid pulse; buffer contents are discarded (count=0).
// TESTING
//  T1: assert reset 2 cycles with sv_valid=1 -> count=0, dec_valid=0, busy=0, mux_d1/d0=00; sv_ready=1 after release.
//  T2: 8 writes of 4'b0000, start_state=00 -> TRACE 8 cycles with selects 00, then dec_valid=1, dec_bit=0, count=7.
//  T3: 8 writes of 4'b1111, start_state=00 -> select sequence 00,01,11,11,11,11,11,11; dec_bit=1.
//  T4: 17 back-to-back writes of 4'b1010 -> sv_ready=0 once count=16; the dropped write leaves count=16.
//      After EMIT: count=15, sv_ready=1.
//  T5: write on the EMIT cycle -> count unchanged across that edge; wr_ptr wraps 15->0 correctly.
//  T6: reset asserted on the 3rd TRACE cycle -> next cycle busy=0, count=0, and no dec_valid for 20 cycles.

Source files
------------

// File: rtl/spdu_tb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spdu_tb_ctrl
//  Purpose  : Traceback controller for the 4-state (K=3) Viterbi survivor
//             path decode unit. Buffers survivor-decision vectors in a
//             circular buffer, sequences the external 4:1 survivor mux for
//             TB_LEN backward steps, then emits one decoded bit and retires
//             the oldest buffered vector.
//  Revision : 1.0  initial release
// ============================================================================
module spdu_tb_ctrl #(
    parameter int TB_LEN = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sv_valid,
    input  logic [3:0] sv_in,
    output logic       sv_ready,
    input  logic [1:0] start_state,
    output logic [3:0] mux_in,
    output logic       mux_d0,
    output logic       mux_d1,
    input  logic       mux_out,
    output logic       dec_bit,
    output logic       dec_valid,
    output logic       busy
);

    localparam int           c_SW     = (TB_LEN > 2) ? $clog2(TB_LEN) : 1;
    localparam logic [AW:0]  c_TB_LEN = (AW+1)'(TB_LEN);
    localparam logic [AW:0]  c_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [c_SW-1:0] c_LAST_STEP = c_SW'(TB_LEN - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_TRACE = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t            r_fsm;
    state_t            w_fsm_nxt;

    logic [3:0]        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [1:0]        r_trace;
    logic [c_SW-1:0]   r_step;

    logic              w_full;
    logic              w_wr_en;
    logic              w_enter;
    logic              w_pop;

    // The oldest resident entry is implied by wr_ptr - count, so no separate
    // tail pointer is kept.
    assign w_full   = (r_count == c_DEPTH);
    assign w_wr_en  = sv_valid && !w_full;
    assign sv_ready = !reset && !w_full;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= S_FILL;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // Next-state logic and mux/decode outputs; everything forced low in reset.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_enter   = 1'b0;
        w_pop     = 1'b0;
        mux_in    = 4'b0000;
        mux_d0    = 1'b0;
        mux_d1    = 1'b0;
        dec_bit   = 1'b0;
        dec_valid = 1'b0;
        busy      = 1'b0;
        case (r_fsm)
            S_FILL: begin
                if (r_count >= c_TB_LEN) begin
                    w_fsm_nxt = S_TRACE;
                    w_enter   = 1'b1;
                end
            end
            S_TRACE: begin
                busy   = !reset;
                mux_in = reset ? 4'b0000 : r_mem[r_rd_ptr];
                mux_d1 = !reset && r_trace[1];
                mux_d0 = !reset && r_trace[0];
                if (r_step == c_LAST_STEP) begin
                    w_fsm_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                busy      = !reset;
                dec_valid = !reset;
                dec_bit   = !reset && r_trace[1];
                w_pop     = 1'b1;
                w_fsm_nxt = S_FILL;
            end
            default: begin
                w_fsm_nxt = S_FILL;
            end
        endcase
    end

    // Survivor storage; contents are don't-care after reset since count=0.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= sv_in;
        end
    end

    // Pointers, occupancy and trace-state datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_trace  <= 2'b00;
            r_step   <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_wr_en} - {{AW{1'b0}}, w_pop};
            if (w_enter) begin
                // Window starts at the newest entry already resident; a
                // same-cycle write lands after it and is not traced.
                r_rd_ptr <= r_wr_ptr - 1'b1;
                r_trace  <= start_state;
                r_step   <= '0;
            end else if (r_fsm == S_TRACE) begin
                r_trace  <= {r_trace[0], mux_out};
                r_rd_ptr <= r_rd_ptr - 1'b1;
                r_step   <= r_step + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spdu_tb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spdu_tb_ctrl
//  Purpose  : Self-checking bench for spdu_tb_ctrl: directed traceback table,
//             multi-cycle corner sequences and randomized traffic checked
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spdu_tb_ctrl;

    localparam int TB_LEN = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic       clk;
    logic       reset;
    logic       sv_valid;
    logic [3:0] sv_in;
    logic       sv_ready;
    logic [1:0] start_state;
    logic [3:0] mux_in;
    logic       mux_d0;
    logic       mux_d1;
    logic       mux_out;
    logic       dec_bit;
    logic       dec_valid;
    logic       busy;

    spdu_tb_ctrl #(.TB_LEN(TB_LEN), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sv_valid   (sv_valid),
        .sv_in      (sv_in),
        .sv_ready   (sv_ready),
        .start_state(start_state),
        .mux_in     (mux_in),
        .mux_d0     (mux_d0),
        .mux_d1     (mux_d1),
        .mux_out    (mux_out),
        .dec_bit    (dec_bit),
        .dec_valid  (dec_valid),
        .busy       (busy)
    );

    // The bench plays the external 4:1 survivor mux.
    logic [1:0] w_sel;
    assign w_sel   = {mux_d1, mux_d0};
    assign mux_out = mux_in[w_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // q holds buffered vectors oldest-first; a traceback snapshots the newest
    // TB_LEN entries and precomputes the whole select path and decoded bit.
    logic [3:0] q[$];
    int         ph = 0;          // 0 fill, 1 trace, 2 emit
    int         tk = 0;
    logic [1:0] esel [TB_LEN];
    logic [3:0] evec [TB_LEN];
    logic       ebit = 1'b0;

    task automatic model_check();
        logic on;
        on = !reset;
        chk("sv_ready",  {31'd0, sv_ready},  {31'd0, on && (q.size() != DEPTH)});
        chk("busy",      {31'd0, busy},      {31'd0, on && (ph != 0)});
        chk("dec_valid", {31'd0, dec_valid}, {31'd0, on && (ph == 2)});
        if (on && ph == 2) chk("dec_bit", {31'd0, dec_bit}, {31'd0, ebit});
        if (on && ph == 1) begin
            chk("mux_sel", {30'd0, w_sel},  {30'd0, esel[tk]});
            chk("mux_in",  {28'd0, mux_in}, {28'd0, evec[tk]});
        end else begin
            chk("mux_sel_idle", {30'd0, w_sel},  32'd0);
            chk("mux_in_idle",  {28'd0, mux_in}, 32'd0);
        end
    endtask

    task automatic model_update();
        logic       acc;
        logic [1:0] s;
        logic [3:0] v;
        int         n;
        if (reset) begin
            q.delete();
            ph = 0;
            tk = 0;
        end else begin
            acc = sv_valid && (q.size() != DEPTH);
            n   = q.size();
            if (ph == 0) begin
                if (n >= TB_LEN) begin
                    s = start_state;
                    for (int k = 0; k < TB_LEN; k++) begin
                        v       = q[n-1-k];
                        esel[k] = s;
                        evec[k] = v;
                        s       = {s[0], v[s]};
                    end
                    ebit = s[1];
                    ph   = 1;
                    tk   = 0;
                end
            end else if (ph == 1) begin
                tk++;
                if (tk == TB_LEN) ph = 2;
            end else begin
                void'(q.pop_front());
                ph = 0;
            end
            if (acc) q.push_back(sv_in);
        end
    endtask

    // One clock cycle: drive at negedge, check, advance model. Returns with
    // time just after the drive point so callers may add extra checks.
    task automatic cyc(input logic r, input logic v, input logic [3:0] d, input logic [1:0] ss);
        @(negedge clk);
        reset       = r;
        sv_valid    = v;
        sv_in       = d;
        start_state = ss;
        #1;
        model_check();
        model_update();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  vec;
        logic [1:0]  ss;
        logic [15:0] sels;   // step k select in bits [2k+1:2k]
        logic        dbit;
    } scen_t;

    scen_t tbl [6];

    initial begin
        int  k;
        bit  got;
        tbl[0] = '{vec: 4'b0000, ss: 2'b00, sels: 16'h0000, dbit: 1'b0};
        tbl[1] = '{vec: 4'b1111, ss: 2'b00, sels: 16'hFFF4, dbit: 1'b1};
        tbl[2] = '{vec: 4'b1010, ss: 2'b00, sels: 16'h0000, dbit: 1'b0};
        tbl[3] = '{vec: 4'b1010, ss: 2'b01, sels: 16'hFFFD, dbit: 1'b1};
        tbl[4] = '{vec: 4'b0101, ss: 2'b10, sels: 16'h6666, dbit: 1'b1};
        tbl[5] = '{vec: 4'b0110, ss: 2'b11, sels: 16'hB6DB, dbit: 1'b0};

        reset = 1'b1; sv_valid = 1'b0; sv_in = 4'd0; start_state = 2'd0;

        for (int t = 0; t < 6; t++) begin
            // Reset with sv_valid high: nothing may be accepted.
            cyc(1'b1, 1'b1, 4'hF, 2'b00);
            cyc(1'b1, 1'b1, 4'hF, 2'b00);
            for (int w = 0; w < TB_LEN; w++) begin
                cyc(1'b0, 1'b1, tbl[t].vec, tbl[t].ss);
                if (w == 0) chk("ready_after_reset", {31'd0, sv_ready}, 32'd1);
            end
            k   = 0;
            got = 1'b0;
            for (int c = 0; c < TB_LEN + 4; c++) begin
                // start_state wiggles after entry and must be ignored.
                cyc(1'b0, 1'b0, 4'h0, (k > 0) ? ~tbl[t].ss : tbl[t].ss);
                if (busy && !dec_valid) begin
                    if (k < TB_LEN)
                        chk("tbl_sel", {30'd0, w_sel}, {30'd0, tbl[t].sels[2*k +: 2]});
                    k++;
                end
                if (dec_valid) begin
                    chk("tbl_bit", {31'd0, dec_bit}, {31'd0, tbl[t].dbit});
                    got = 1'b1;
                end
            end
            chk("tbl_trace_len", k, TB_LEN);
            chk("tbl_emitted", {31'd0, got}, 32'd1);
        end

        // Back-to-back writes into a full buffer; the 17th is dropped.
        cyc(1'b1, 1'b0, 4'h0, 2'b00);
        for (int w = 1; w <= 17; w++) begin
            cyc(1'b0, 1'b1, 4'b1010, 2'b00);
            if (w == 17) chk("full_not_ready", {31'd0, sv_ready}, 32'd0);
        end
        cyc(1'b0, 1'b0, 4'h0, 2'b00);
        chk("full_emit", {31'd0, dec_valid}, 32'd1);
        cyc(1'b0, 1'b0, 4'h0, 2'b00);
        chk("ready_after_pop", {31'd0, sv_ready}, 32'd1);

        // Reset on the third TRACE cycle aborts without a decode pulse.
        cyc(1'b1, 1'b0, 4'h0, 2'b00);
        for (int w = 0; w < TB_LEN; w++) cyc(1'b0, 1'b1, 4'b0110, 2'b00);
        cyc(1'b0, 1'b0, 4'h0, 2'b00);
        cyc(1'b0, 1'b0, 4'h0, 2'b00);
        cyc(1'b0, 1'b0, 4'h0, 2'b00);
        chk("trace_before_abort", {31'd0, busy}, 32'd1);
        cyc(1'b1, 1'b0, 4'h0, 2'b00);
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 1'b0, 4'h0, 2'b00);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_no_dv", {31'd0, dec_valid}, 32'd0);
        end
        // Buffer must be empty: 7 more writes still do not start a trace.
        for (int w = 0; w < TB_LEN - 1; w++) cyc(1'b0, 1'b1, 4'h3, 2'b00);
        cyc(1'b0, 1'b0, 4'h0, 2'b00);
        cyc(1'b0, 1'b0, 4'h0, 2'b00);
        chk("abort_count_zero", {31'd0, busy}, 32'd0);

        // Randomized traffic, including writes on EMIT cycles, pointer wrap
        // and occasional resets, all checked against the model.
        cyc(1'b1, 1'b0, 4'h0, 2'b00);
        for (int c = 0; c < 4000; c++) begin
            cyc(($urandom_range(0, 499) == 0),
                ($urandom_range(0, 99) < 60),
                4'($urandom),
                2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
